// File: rtl/sync_fifo_v2.sv
// Single-clock FIFO with an arbitrary (non power-of-two) depth, runtime almost-full/empty thresholds,
// sticky overflow/underflow flags, and a choice of registered or first-word fall-through read port.
module sync_fifo_v2 #(
  parameter int FIFO_LEN = 16,
  parameter int DATA_WTH = 8,
  parameter int ADDR_WTH = 4,
  parameter int CNT_WTH  = ADDR_WTH + 1,
  parameter int RD_MODE  = 0
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                flush_i,
  input  logic [DATA_WTH-1:0] wr_data_i,
  input  logic                wr_en_i,
  output logic                full_o,
  output logic                a_full_o,
  input  logic [CNT_WTH-1:0]  a_full_thr_i,
  input  logic                rd_en_i,
  output logic [DATA_WTH-1:0] rd_data_o,
  output logic                rd_valid_o,
  output logic                empty_o,
  output logic                a_empty_o,
  input  logic [CNT_WTH-1:0]  a_empty_thr_i,
  output logic [CNT_WTH-1:0]  count_o,
  output logic                ovf_o,
  output logic                udf_o,
  input  logic                err_clr_i
);

  logic [DATA_WTH-1:0] mem_q [FIFO_LEN];
  logic [ADDR_WTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_WTH-1:0]  count_q, count_d;
  logic                a_full_q, a_empty_q;
  logic                ovf_q, udf_q;
  logic                full, empty;
  logic                wr_acc, rd_acc;

  assign full   = (count_q == CNT_WTH'(FIFO_LEN));
  assign empty  = (count_q == '0);
  assign wr_acc = wr_en_i & ~full & ~flush_i & ~rst_i;
  assign rd_acc = rd_en_i & ~empty & ~flush_i & ~rst_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_acc)
        wr_ptr_d = (wr_ptr_q == ADDR_WTH'(FIFO_LEN - 1)) ? '0 : wr_ptr_q + ADDR_WTH'(1);
      if (rd_acc)
        rd_ptr_d = (rd_ptr_q == ADDR_WTH'(FIFO_LEN - 1)) ? '0 : rd_ptr_q + ADDR_WTH'(1);
      if (wr_acc && !rd_acc)
        count_d = count_q + CNT_WTH'(1);
      else if (rd_acc && !wr_acc)
        count_d = count_q - CNT_WTH'(1);
    end
  end

  // Storage is deliberately left out of reset so it maps onto plain RAM.
  always_ff @(posedge clk_i) begin
    if (wr_acc)
      mem_q[wr_ptr_q] <= wr_data_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      a_full_q  <= (a_full_thr_i == '0);
      a_empty_q <= 1'b1;
      ovf_q     <= 1'b0;
      udf_q     <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      // Flags track the count being loaded, so they never lag count_o.
      a_full_q  <= (count_d >= a_full_thr_i);
      a_empty_q <= (count_d <= a_empty_thr_i);
      ovf_q     <= (wr_en_i & full & ~flush_i) | (ovf_q & ~err_clr_i);
      udf_q     <= (rd_en_i & empty & ~flush_i) | (udf_q & ~err_clr_i);
    end
  end

  generate
    if (RD_MODE == 0) begin : g_std_rd
      logic [DATA_WTH-1:0] rd_data_q;
      logic                rd_valid_q;

      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          rd_data_q  <= '0;
          rd_valid_q <= 1'b0;
        end else begin
          rd_valid_q <= rd_acc;
          if (rd_acc)
            rd_data_q <= mem_q[rd_ptr_q];
        end
      end

      assign rd_data_o  = rd_data_q;
      assign rd_valid_o = rd_valid_q;
    end else begin : g_fwft_rd
      assign rd_data_o  = mem_q[rd_ptr_q];
      assign rd_valid_o = ~empty;
    end
  endgenerate

  assign full_o    = full;
  assign empty_o   = empty;
  assign count_o   = count_q;
  assign a_full_o  = a_full_q;
  assign a_empty_o = a_empty_q;
  assign ovf_o     = ovf_q;
  assign udf_o     = udf_q;

endmodule

// File: tb/tb_sync_fifo_v2.sv
// Drives a standard-read and an FWFT instance of sync_fifo_v2 in lockstep and compares both
// against a queue-based reference model after every clock edge.
module tb_sync_fifo_v2;

  localparam int LEN = 6;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b0, flush_i = 1'b0, wr_en_i = 1'b0, rd_en_i = 1'b0, err_clr_i = 1'b0;
  logic [7:0] wr_data_i = '0;
  logic [3:0] a_full_thr_i = 4'd5, a_empty_thr_i = 4'd1;

  logic       full0, a_full0, rd_valid0, empty0, a_empty0, ovf0, udf0;
  logic       full1, a_full1, rd_valid1, empty1, a_empty1, ovf1, udf1;
  logic [7:0] rd_data0, rd_data1;
  logic [3:0] count0, count1;

  int checks = 0;
  int errors = 0;

  // reference model state
  byte unsigned m_q[$];
  logic         m_ovf = 1'b0, m_udf = 1'b0, m_rdv = 1'b0;
  logic [7:0]   m_rdd = '0;
  logic         m_afull = 1'b0, m_aempty = 1'b1;

  always #5 clk_i = ~clk_i;

  sync_fifo_v2 #(.FIFO_LEN(LEN), .DATA_WTH(8), .ADDR_WTH(3), .CNT_WTH(4), .RD_MODE(0)) u_std (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .wr_data_i(wr_data_i), .wr_en_i(wr_en_i),
    .full_o(full0), .a_full_o(a_full0), .a_full_thr_i(a_full_thr_i), .rd_en_i(rd_en_i),
    .rd_data_o(rd_data0), .rd_valid_o(rd_valid0), .empty_o(empty0), .a_empty_o(a_empty0),
    .a_empty_thr_i(a_empty_thr_i), .count_o(count0), .ovf_o(ovf0), .udf_o(udf0),
    .err_clr_i(err_clr_i)
  );

  sync_fifo_v2 #(.FIFO_LEN(LEN), .DATA_WTH(8), .ADDR_WTH(3), .CNT_WTH(4), .RD_MODE(1)) u_fwft (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .wr_data_i(wr_data_i), .wr_en_i(wr_en_i),
    .full_o(full1), .a_full_o(a_full1), .a_full_thr_i(a_full_thr_i), .rd_en_i(rd_en_i),
    .rd_data_o(rd_data1), .rd_valid_o(rd_valid1), .empty_o(empty1), .a_empty_o(a_empty1),
    .a_empty_thr_i(a_empty_thr_i), .count_o(count1), .ovf_o(ovf1), .udf_o(udf1),
    .err_clr_i(err_clr_i)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    int  n = m_q.size();
    bit  was_full = (n == LEN);
    bit  was_empty = (n == 0);
    if (rst_i) begin
      m_q.delete();
      m_ovf = 1'b0; m_udf = 1'b0; m_rdv = 1'b0; m_rdd = '0;
    end else if (flush_i) begin
      m_q.delete();
      m_rdv = 1'b0;
      m_ovf = m_ovf & ~err_clr_i;
      m_udf = m_udf & ~err_clr_i;
    end else begin
      m_rdv = rd_en_i && !was_empty;
      if (m_rdv) m_rdd = m_q.pop_front();
      if (wr_en_i && !was_full) m_q.push_back(wr_data_i);
      m_ovf = (wr_en_i && was_full) | (m_ovf & ~err_clr_i);
      m_udf = (rd_en_i && was_empty) | (m_udf & ~err_clr_i);
    end
    m_afull  = (m_q.size() >= int'(a_full_thr_i));
    m_aempty = (m_q.size() <= int'(a_empty_thr_i));
  endtask

  task automatic check_all();
    int n = m_q.size();
    chk("count",    32'(count0),   32'(n));
    chk("full",     32'(full0),    32'(n == LEN));
    chk("empty",    32'(empty0),   32'(n == 0));
    chk("a_full",   32'(a_full0),  32'(m_afull));
    chk("a_empty",  32'(a_empty0), 32'(m_aempty));
    chk("ovf",      32'(ovf0),     32'(m_ovf));
    chk("udf",      32'(udf0),     32'(m_udf));
    chk("rd_valid", 32'(rd_valid0), 32'(m_rdv));
    chk("rd_data",  32'(rd_data0), 32'(m_rdd));
    chk("fwft_count", 32'(count1), 32'(n));
    chk("fwft_flags", {28'd0, a_full1, a_empty1, ovf1, udf1},
        {28'd0, m_afull, m_aempty, m_ovf, m_udf});
    chk("fwft_valid", 32'(rd_valid1), 32'(n != 0));
    if (n != 0) chk("fwft_data", 32'(rd_data1), 32'(m_q[0]));
  endtask

  task automatic cyc(input logic w, input logic [7:0] d, input logic r,
                     input logic f = 1'b0, input logic c = 1'b0, input logic rs = 1'b0);
    wr_en_i = w; wr_data_i = d; rd_en_i = r; flush_i = f; err_clr_i = c; rst_i = rs;
    @(posedge clk_i);
    model_edge();
    #1;
    check_all();
  endtask

  initial begin
    cyc(0, 8'h00, 0, 0, 0, 1);
    cyc(0, 8'h00, 0, 0, 0, 1);
    chk("reset_rd_data", 32'(rd_data0), 32'h0);
    cyc(0, 8'h00, 0);

    // overfill then drain in order
    for (int i = 0; i < 7; i++) cyc(1, 8'h11 + 8'(i), 0);
    chk("ovf_after_fill", 32'(ovf0), 32'h1);
    cyc(0, 8'h00, 0, 0, 1);
    for (int i = 0; i < 7; i++) cyc(0, 8'h00, 1);
    cyc(0, 8'h00, 0, 0, 1);

    // steady-state wr+rd with pointer wrap
    for (int i = 0; i < 4; i++) cyc(1, 8'h40 + 8'(i), 0);
    for (int i = 0; i < 10; i++) cyc(1, 8'h50 + 8'(i), 1);
    chk("steady_count", 32'(count0), 32'd4);
    for (int i = 0; i < 4; i++) cyc(0, 8'h00, 1);

    // read latency in both modes
    cyc(1, 8'hA5, 0);
    chk("fwft_first_word", 32'(rd_data1), 32'hA5);
    cyc(0, 8'h00, 1);
    chk("std_first_word", 32'(rd_data0), 32'hA5);
    cyc(0, 8'h00, 0);

    // threshold walk 0 -> 6 -> 0
    a_full_thr_i = 4'd5; a_empty_thr_i = 4'd1;
    for (int i = 0; i < 6; i++) cyc(1, 8'h60 + 8'(i), 0);
    for (int i = 0; i < 6; i++) cyc(0, 8'h00, 1);

    // flush with a concurrent write, then underflow and clear
    for (int i = 0; i < 3; i++) cyc(1, 8'h70 + 8'(i), 0);
    cyc(1, 8'h7F, 0, 1);
    chk("flush_empty", 32'(empty0), 32'h1);
    cyc(0, 8'h00, 1);
    chk("udf_set", 32'(udf0), 32'h1);
    cyc(0, 8'h00, 0, 0, 1);

    // reset mid-stream
    for (int i = 0; i < 4; i++) cyc(1, 8'h80 + 8'(i), 0);
    cyc(1, 8'h90, 1, 0, 0, 1);
    chk("rst_midstream_count", 32'(count0), 32'h0);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 19) == 0) begin
        a_full_thr_i  = 4'($urandom_range(0, 6));
        a_empty_thr_i = 4'($urandom_range(0, 6));
      end
      cyc(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
          $urandom_range(0, 29) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 79) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sync_fifo_v2.md
SYNC_FIFO_V2 -- requirements
Module: sync_fifo_v2

Interface
REQ-001 SHALL have parameter FIFO_LEN, default 16, meaning entry count; any integer >= 2, not restricted to powers of two.
REQ-002 SHALL have parameter DATA_WTH, default 8, meaning word width in bits.
REQ-003 SHALL have parameter ADDR_WTH, default 4, meaning pointer width; ceil(log2(FIFO_LEN)).
REQ-004 SHALL have parameter CNT_WTH, default ADDR_WTH+1, meaning occupancy/threshold width; holds 0..FIFO_LEN.
REQ-005 SHALL have parameter RD_MODE, default 0, meaning 0 = standard registered read, 1 = first-word fall-through (FWFT).
REQ-006 SHALL have port clk_i  input  1  clock; single clock domain, rising edge.
REQ-007 SHALL have port rst_i  input  1  reset; synchronous, active-high.
REQ-008 SHALL have port flush_i  input  1  synchronous clear of FIFO contents.
REQ-009 SHALL have port wr_data_i  input  DATA_WTH  write word.
REQ-010 SHALL have port wr_en_i  input  1  write request.
REQ-011 SHALL have port full_o  output  1  FIFO holds FIFO_LEN words.
REQ-012 SHALL have port a_full_o  output  1  almost full, count >= a_full_thr_i.
REQ-013 SHALL have port a_full_thr_i  input  CNT_WTH  almost-full threshold, runtime.
REQ-014 SHALL have port rd_en_i  input  1  read request / pop.
REQ-015 SHALL have port rd_data_o  output  DATA_WTH  read word.
REQ-016 SHALL have port rd_valid_o  output  1  rd_data_o valid.
REQ-017 SHALL have port empty_o  output  1  FIFO holds 0 words.
REQ-018 SHALL have port a_empty_o  output  1  almost empty, count <= a_empty_thr_i.
REQ-019 SHALL have port a_empty_thr_i  input  CNT_WTH  almost-empty threshold, runtime.
REQ-020 SHALL have port count_o  output  CNT_WTH  current occupancy.
REQ-021 SHALL have port ovf_o  output  1  sticky overflow flag.
REQ-022 SHALL have port udf_o  output  1  sticky underflow flag.
REQ-023 SHALL have port err_clr_i  input  1  clears ovf_o/udf_o.

Function
REQ-024 Write accepted iff wr_en_i & ~full_o & ~flush_i; word stored at wr pointer, pointer increments, wraps FIFO_LEN-1 -> 0.
REQ-025 Read accepted iff rd_en_i & ~empty_o & ~flush_i; rd pointer increments, wraps FIFO_LEN-1 -> 0.
REQ-026 count_o registered: +1 on write-only, -1 on read-only, unchanged on both or neither; full_o = (count_o == FIFO_LEN), empty_o = (count_o == 0).
REQ-027 Simultaneous wr/rd at full: read only accepted, write dropped; at empty: write only accepted, no bypass to read side.
REQ-028 RD_MODE=0: rd_data_o registered, loaded with head word on accepted read, held otherwise; rd_valid_o = 1 for exactly the cycle after each accepted read.
REQ-029 RD_MODE=1: rd_data_o = head word, rd_valid_o = ~empty_o; rd_en_i acknowledges/pops the shown word; first written word visible one cycle after its write.
REQ-030 a_full_o, a_empty_o registered, computed from next-cycle count and current thresholds, so always consistent with count_o in the same cycle.
REQ-031 ovf_o set on wr_en_i & full_o; udf_o set on rd_en_i & empty_o; both held until err_clr_i or rst_i; set has priority over err_clr_i in same cycle.
REQ-032 flush_i: pointers and count to 0, rd_valid_o to 0, a_* recomputed for count 0; wr/rd requests that cycle ignored and not flagged as errors; memory contents and rd_data_o unchanged.
REQ-033 Occupancy never exceeds FIFO_LEN nor drops below 0 under any input sequence.

Reset
REQ-034 On rst_i: count_o 0, empty_o 1, full_o 0, a_empty_o 1, a_full_o 0 (0 if a_full_thr_i > 0), rd_valid_o 0, rd_data_o 0, ovf_o 0, udf_o 0; memory not cleared; rst_i overrides all other inputs.

Verification (FIFO_LEN=6, DATA_WTH=8)
REQ-035 Write 0x11..0x16, 7th write 0x17 -> full_o=1, count_o=6, ovf_o=1; reads return 0x11..0x16 in order, 0x17 never appears.
REQ-036 Fill 4, then 10 cycles of wr+rd together -> count_o stays 4, pointers wrap past index 5, data order preserved.
REQ-037 RD_MODE=1, write 0xA5 at cycle n -> rd_data_o=0xA5, rd_valid_o=1 at n+1 without rd_en_i; RD_MODE=0 same write, rd_en_i at n+1 -> 0xA5, rd_valid_o=1 at n+2.
REQ-038 a_full_thr_i=5, a_empty_thr_i=1: count 0->6->0 -> a_empty_o deasserts at count 2, a_full_o asserts at count 5, deasserts at count 4, a_empty_o reasserts at count 1.
REQ-039 Count 3, flush_i with wr_en_i=1 -> count_o=0, empty_o=1, ovf_o=0; rd_en_i on empty -> udf_o=1; err_clr_i -> udf_o=0.
REQ-040 rst_i asserted mid-stream at count 4 with wr_en_i=rd_en_i=1 -> next cycle all outputs at REQ-034 values.
